// File: rtl/sine_tone_analyzer_pkg.sv
// Shared types for the sine tone analyzer: FSM state encoding, the packed
// measurement-result payload and a log2 helper for the period averaging shift.
package sine_tone_analyzer_pkg;

    localparam int unsigned STA_DATA_W = 12;
    localparam int unsigned STA_CNT_W  = 24;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        MEAS = 2'd2,
        DONE = 2'd3
    } tone_state_e;

    // One measurement result as published on the result outputs
    typedef struct packed {
        logic [STA_CNT_W-1:0]  period_sum;
        logic [STA_CNT_W-1:0]  period_avg;
        logic [STA_DATA_W-1:0] peak_max;
        logic [STA_DATA_W-1:0] peak_min;
        logic [STA_DATA_W-1:0] ampl;
        logic [STA_DATA_W-1:0] offset;
    } tone_result_t;

    // floor(log2(n)); exact for the power-of-two period counts used here
    function automatic int unsigned log2_floor(input int unsigned n);
        int unsigned v;
        int unsigned r;
        v = n;
        r = 0;
        while (v > 1) begin
            v = v >> 1;
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/sine_tone_analyzer_zc_hyst_det.sv
// Hysteresis zero-crossing detector.
// Tracks a HIGH/LOW level of the incoming signal around a midpoint with a
// +/-HYST dead band and strobes rise_c on the accepted sample that moves the
// level from LOW to HIGH.
//   clk, rst   clock, synchronous active-high reset (level -> LOW)
//   clr        force level LOW (analyzer idle)
//   mid        signed crossing midpoint
//   din        signed sample, din_valid qualifies it
//   rise_c     combinational rising-crossing strobe for the current sample
module sine_tone_analyzer_zc_hyst_det
    import sine_tone_analyzer_pkg::*;
#(
    parameter int unsigned DATA_W = STA_DATA_W,
    parameter int unsigned HYST   = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr,
    input  logic signed [DATA_W-1:0] mid,
    input  logic signed [DATA_W-1:0] din,
    input  logic                     din_valid,
    output logic                     rise_c
);

    localparam int unsigned EXT_W = DATA_W + 1;

    logic                    level_q;
    logic                    level_d;
    logic signed [EXT_W-1:0] din_x;
    logic signed [EXT_W-1:0] hi_thr;
    logic signed [EXT_W-1:0] lo_thr;

    // Thresholds in one extra bit so mid +/- HYST never wraps
    always_comb begin
        din_x  = EXT_W'(din);
        hi_thr = EXT_W'(mid) + $signed(EXT_W'(HYST));
        lo_thr = EXT_W'(mid) - $signed(EXT_W'(HYST));
    end

    // Level update with dead band; inside the band the level holds
    always_comb begin
        level_d = level_q;
        rise_c  = 1'b0;
        if (clr) begin
            level_d = 1'b0;
        end else if (din_valid) begin
            if (din_x >= hi_thr) begin
                level_d = 1'b1;
                rise_c  = ~level_q;
            end else if (din_x <= lo_thr) begin
                level_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            level_q <= 1'b0;
        end else begin
            level_q <= level_d;
        end
    end

endmodule

// File: rtl/sine_tone_analyzer.sv
// Sine tone analyzer: measures period, peaks, amplitude and DC offset of a
// signed sample stream over N_PERIODS full cycles between rising crossings.
//   clk, rst        clock, synchronous active-high reset
//   en              enable; low aborts and returns to IDLE
//   continuous      1: keep measuring back to back; 0: single shot
//   mid_thr         signed crossing midpoint, latched when leaving IDLE
//   din, din_valid  signed sample and its qualifier
//   busy            analyzer not idle
//   res_valid       1-cycle pulse, result outputs just updated
//   period_sum/avg  samples over the window / per period
//   peak_max/min    signed extremes in the window
//   ampl, offset    half peak-to-peak (unsigned), mid-range (signed)
//   timeout         1-cycle pulse, no rising crossing within TIMEOUT_SMP samples
module sine_tone_analyzer
    import sine_tone_analyzer_pkg::*;
#(
    parameter int unsigned DATA_W      = STA_DATA_W,
    parameter int unsigned CNT_W       = STA_CNT_W,
    parameter int unsigned N_PERIODS   = 4,
    parameter int unsigned HYST        = 8,
    parameter int unsigned TIMEOUT_SMP = 4096
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              continuous,
    input  logic [DATA_W-1:0] mid_thr,
    input  logic [DATA_W-1:0] din,
    input  logic              din_valid,
    output logic              busy,
    output logic              res_valid,
    output logic [CNT_W-1:0]  period_sum,
    output logic [CNT_W-1:0]  period_avg,
    output logic [DATA_W-1:0] peak_max,
    output logic [DATA_W-1:0] peak_min,
    output logic [DATA_W-1:0] ampl,
    output logic [DATA_W-1:0] offset,
    output logic              timeout
);

    localparam int unsigned EXT_W = DATA_W + 1;
    localparam int unsigned NC_W  = (N_PERIODS > 1) ? $clog2(N_PERIODS) : 1;
    localparam int unsigned TC_W  = $clog2(TIMEOUT_SMP + 1);
    localparam int unsigned LOG2N = log2_floor(N_PERIODS);
    localparam longint unsigned MAX_SUM = 64'(TIMEOUT_SMP) * 64'(N_PERIODS);

    // Elaboration-time parameter sanity checks
    generate
        if (DATA_W != STA_DATA_W || CNT_W != STA_CNT_W) begin : g_chk_width
            $error("DATA_W/CNT_W must match the result payload widths");
        end
        if (N_PERIODS == 0 || (N_PERIODS & (N_PERIODS - 1)) != 0) begin : g_chk_n
            $error("N_PERIODS must be a power of two >= 1");
        end
        if (MAX_SUM >= (64'd1 << CNT_W)) begin : g_chk_sum
            $error("TIMEOUT_SMP*N_PERIODS must be below 2^CNT_W");
        end
        if (TIMEOUT_SMP < 2) begin : g_chk_tmo
            $error("TIMEOUT_SMP must be at least 2");
        end
        if (HYST >= (1 << (DATA_W - 2))) begin : g_chk_hyst
            $error("HYST must be below 2^(DATA_W-2)");
        end
    endgenerate

    tone_state_e              state_q, state_d;
    logic                     stop_q, stop_d;
    logic signed [DATA_W-1:0] mid_q, mid_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic [NC_W-1:0]          ncross_q, ncross_d;
    logic [TC_W-1:0]          tcnt_q, tcnt_d;
    logic signed [DATA_W-1:0] max_q, max_d;
    logic signed [DATA_W-1:0] min_q, min_d;
    tone_result_t             res_q, res_d;
    logic                     res_valid_q, res_valid_d;
    logic                     timeout_q, timeout_d;
    logic                     busy_q, busy_d;

    logic signed [DATA_W-1:0] din_s;
    logic                     rise_c;
    logic [CNT_W-1:0]         cnt_inc;
    logic [TC_W-1:0]          tcnt_inc;
    logic                     tmo_hit;
    logic                     last_cross;
    logic signed [DATA_W-1:0] max_upd;
    logic signed [DATA_W-1:0] min_upd;
    logic signed [EXT_W-1:0]  diff_x;
    logic signed [EXT_W-1:0]  sum_x;
    tone_result_t             result_c;

    assign din_s = $signed(din);

    sine_tone_analyzer_zc_hyst_det #(
        .DATA_W (DATA_W),
        .HYST   (HYST)
    ) u_zc (
        .clk       (clk),
        .rst       (rst),
        .clr       (state_q == IDLE),
        .mid       (mid_q),
        .din       (din_s),
        .din_valid (din_valid),
        .rise_c    (rise_c)
    );

    // Counter increments, trackers and the result computed from the window so far
    always_comb begin
        cnt_inc    = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);
        tcnt_inc   = tcnt_q + TC_W'(1);
        tmo_hit    = (tcnt_inc == TC_W'(TIMEOUT_SMP));
        last_cross = (ncross_q == NC_W'(N_PERIODS - 1));
        max_upd    = (din_s > max_q) ? din_s : max_q;
        min_upd    = (din_s < min_q) ? din_s : min_q;
        diff_x     = EXT_W'(max_q) - EXT_W'(min_q);
        sum_x      = EXT_W'(max_q) + EXT_W'(min_q);
        result_c.period_sum = cnt_q;
        result_c.period_avg = cnt_q >> LOG2N;
        result_c.peak_max   = max_q;
        result_c.peak_min   = min_q;
        result_c.ampl       = DATA_W'(diff_x >> 1);
        result_c.offset     = DATA_W'(sum_x >>> 1);
    end

    // Next-state and datapath control
    always_comb begin
        state_d     = state_q;
        stop_d      = stop_q;
        mid_d       = mid_q;
        cnt_d       = cnt_q;
        ncross_d    = ncross_q;
        tcnt_d      = tcnt_q;
        max_d       = max_q;
        min_d       = min_q;
        res_d       = res_q;
        res_valid_d = 1'b0;
        timeout_d   = 1'b0;

        if (!en) begin
            state_d = IDLE;
            stop_d  = 1'b0;
        end else begin
            unique case (state_q)
                // stop_q keeps a finished single-shot run parked until en drops
                IDLE: begin
                    if (!stop_q) begin
                        state_d = ARM;
                        mid_d   = $signed(mid_thr);
                        tcnt_d  = '0;
                    end
                end
                ARM: begin
                    if (din_valid) begin
                        if (rise_c) begin
                            state_d  = MEAS;
                            cnt_d    = CNT_W'(1);
                            ncross_d = '0;
                            tcnt_d   = '0;
                            max_d    = din_s;
                            min_d    = din_s;
                        end else if (tmo_hit) begin
                            timeout_d = 1'b1;
                            tcnt_d    = '0;
                            if (!continuous) begin
                                state_d = IDLE;
                                stop_d  = 1'b1;
                            end
                        end else begin
                            tcnt_d = tcnt_inc;
                        end
                    end
                end
                MEAS: begin
                    if (din_valid) begin
                        if (rise_c && last_cross) begin
                            // Final crossing closes this window and seeds the next
                            res_d       = result_c;
                            res_valid_d = 1'b1;
                            state_d     = DONE;
                            cnt_d       = CNT_W'(1);
                            ncross_d    = '0;
                            tcnt_d      = '0;
                            max_d       = din_s;
                            min_d       = din_s;
                        end else if (rise_c) begin
                            ncross_d = ncross_q + NC_W'(1);
                            cnt_d    = cnt_inc;
                            max_d    = max_upd;
                            min_d    = min_upd;
                            tcnt_d   = '0;
                        end else if (tmo_hit) begin
                            timeout_d = 1'b1;
                            tcnt_d    = '0;
                            if (continuous) begin
                                state_d = ARM;
                            end else begin
                                state_d = IDLE;
                                stop_d  = 1'b1;
                            end
                        end else begin
                            cnt_d  = cnt_inc;
                            max_d  = max_upd;
                            min_d  = min_upd;
                            tcnt_d = tcnt_inc;
                        end
                    end
                end
                // Level is HIGH right after a crossing, so no crossing or
                // timeout can occur on a sample taken here
                DONE: begin
                    if (continuous) begin
                        state_d = MEAS;
                        if (din_valid) begin
                            cnt_d  = cnt_inc;
                            max_d  = max_upd;
                            min_d  = min_upd;
                            tcnt_d = tcnt_inc;
                        end
                    end else begin
                        state_d = IDLE;
                        stop_d  = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            stop_q      <= 1'b0;
            mid_q       <= '0;
            cnt_q       <= '0;
            ncross_q    <= '0;
            tcnt_q      <= '0;
            max_q       <= '0;
            min_q       <= '0;
            res_q       <= '0;
            res_valid_q <= 1'b0;
            timeout_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            stop_q      <= stop_d;
            mid_q       <= mid_d;
            cnt_q       <= cnt_d;
            ncross_q    <= ncross_d;
            tcnt_q      <= tcnt_d;
            max_q       <= max_d;
            min_q       <= min_d;
            res_q       <= res_d;
            res_valid_q <= res_valid_d;
            timeout_q   <= timeout_d;
            busy_q      <= busy_d;
        end
    end

    assign busy       = busy_q;
    assign res_valid  = res_valid_q;
    assign timeout    = timeout_q;
    assign period_sum = res_q.period_sum;
    assign period_avg = res_q.period_avg;
    assign peak_max   = res_q.peak_max;
    assign peak_min   = res_q.peak_min;
    assign ampl       = res_q.ampl;
    assign offset     = res_q.offset;

endmodule

// File: tb/tb_sine_tone_analyzer.sv
// Scoreboard bench for sine_tone_analyzer: directed streams push expected
// results into a queue; a negedge monitor pops and compares on every
// res_valid / timeout pulse.
module tb_sine_tone_analyzer;

    logic        clk;
    logic        rst;
    logic        en;
    logic        continuous;
    logic [11:0] mid_thr;
    logic [11:0] din;
    logic        din_valid;
    logic        busy;
    logic        res_valid;
    logic [23:0] period_sum;
    logic [23:0] period_avg;
    logic [11:0] peak_max;
    logic [11:0] peak_min;
    logic [11:0] ampl;
    logic [11:0] offset;
    logic        timeout;

    sine_tone_analyzer #(
        .DATA_W      (12),
        .CNT_W       (24),
        .N_PERIODS   (4),
        .HYST        (8),
        .TIMEOUT_SMP (4096)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .continuous (continuous),
        .mid_thr    (mid_thr),
        .din        (din),
        .din_valid  (din_valid),
        .busy       (busy),
        .res_valid  (res_valid),
        .period_sum (period_sum),
        .period_avg (period_avg),
        .peak_max   (peak_max),
        .peak_min   (peak_min),
        .ampl       (ampl),
        .offset     (offset),
        .timeout    (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit is_tmo;
        int psum;
        int pavg;
        int pmax;
        int pmin;
        int ampl;
        int offs;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   n_cmp = 0;
    int   n_err = 0;
    bit   gap   = 1'b0;
    bit   gsel  = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push_res(input int ps, input int pa, input int mx, input int mn,
                            input int am, input int of);
        exp_t e;
        e.is_tmo = 1'b0; e.psum = ps; e.pavg = pa; e.pmax = mx;
        e.pmin = mn; e.ampl = am; e.offs = of;
        q.push_back(e);
    endtask

    task automatic push_tmo();
        exp_t e;
        e.is_tmo = 1'b1; e.psum = 0; e.pavg = 0; e.pmax = 0;
        e.pmin = 0; e.ampl = 0; e.offs = 0;
        q.push_back(e);
    endtask

    // Drive one cycle, return 1 time unit after the accepting edge
    task automatic drive(input int v, input bit valid);
        din       = 12'(v);
        din_valid = valid;
        @(posedge clk);
        #1;
    endtask

    // One valid sample, optionally followed by an invalid cycle carrying junk
    task automatic smp(input int v);
        drive(v, 1'b1);
        if (gap) begin
            gsel = ~gsel;
            drive(gsel ? 2047 : -2048, 1'b0);
        end
    endtask

    task automatic start_test(input int mid, input bit cont);
        en         = 1'b0;
        continuous = cont;
        mid_thr    = 12'(mid);
        drive(0, 1'b0);
        en = 1'b1;
        drive(0, 1'b0);
    endtask

    function automatic int sine40(input int k);
        real r;
        r = 1000.0 * $sin(2.0 * 3.14159265358979 * real'(k) / 40.0);
        return 200 + ((r >= 0.0) ? $rtoi(r + 0.5) : $rtoi(r - 0.5));
    endfunction

    // Monitor: every output pulse must match the head of the expected queue
    always @(negedge clk) begin
        if (!rst && (res_valid || timeout)) begin
            if (q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_pulse: res_valid=%0b timeout=%0b with nothing expected (t=%0t)",
                         res_valid, timeout, $time);
            end else begin
                mon_e = q.pop_front();
                chk("pulse_timeout", int'(timeout), int'(mon_e.is_tmo));
                chk("pulse_res_valid", int'(res_valid), int'(!mon_e.is_tmo));
                if (!mon_e.is_tmo) begin
                    chk("period_sum", int'(period_sum), mon_e.psum);
                    chk("period_avg", int'(period_avg), mon_e.pavg);
                    chk("peak_max", int'($signed(peak_max)), mon_e.pmax);
                    chk("peak_min", int'($signed(peak_min)), mon_e.pmin);
                    chk("ampl", int'(ampl), mon_e.ampl);
                    chk("offset", int'($signed(offset)), mon_e.offs);
                end
            end
        end
    end

    // Period-20 tone with +/-5 LSB jitter parked around the midpoint
    int t4_tab [20] = '{3, -5, 5, 300, 500, 600, 500, 300, 100, 4,
                        -5, 5, -3, -300, -500, -600, -500, -300, -100, -4};

    initial begin
        rst        = 1'b1;
        en         = 1'b0;
        continuous = 1'b0;
        mid_thr    = '0;
        din        = '0;
        din_valid  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", int'(busy), 0);
        chk("rst_res_valid", int'(res_valid), 0);
        chk("rst_timeout", int'(timeout), 0);
        chk("rst_period_sum", int'(period_sum), 0);
        chk("rst_peak_max", int'(peak_max), 0);
        rst = 1'b0;

        // 1: sine, period 40, ampl 1000, offset 200, single shot
        start_test(200, 1'b0);
        chk("t1_busy_armed", int'(busy), 1);
        push_res(160, 40, 1200, -800, 1000, 200);
        for (int k = 20; k <= 205; k++) smp(sine40(k));
        chk("t1_busy_after", int'(busy), 0);

        // 2: square +/-500 period 8, exact latency
        start_test(0, 1'b0);
        push_res(32, 8, 500, -500, 500, 0);
        repeat (4) smp(-500);
        for (int p = 1; p <= 5; p++) begin
            if (p == 5) chk("t2_before_final", int'(res_valid), 0);
            smp(500);
            if (p == 5) chk("t2_latency", int'(res_valid), 1);
            smp(500);
            if (p == 5) chk("t2_pulse_width", int'(res_valid), 0);
            repeat (2) smp(500);
            repeat (4) smp(-500);
        end

        // 3: flat input, timeout on the 4096th sample
        start_test(0, 1'b0);
        push_tmo();
        repeat (4095) smp(0);
        chk("t3_no_early_timeout", int'(timeout), 0);
        smp(0);
        chk("t3_timeout_4096", int'(timeout), 1);
        smp(0);
        chk("t3_busy_after", int'(busy), 0);

        // 4: jitter inside hysteresis must not add crossings
        start_test(0, 1'b0);
        push_res(80, 20, 600, -600, 600, 0);
        for (int k = 0; k < 90; k++) smp(t4_tab[k % 20]);

        // 5: continuous, 50% valid, three back-to-back windows
        start_test(200, 1'b1);
        gap = 1'b1;
        repeat (3) push_res(32, 8, 700, -300, 500, 200);
        repeat (5) smp(-300);
        for (int p = 1; p <= 12; p++) begin
            repeat (3) smp(700);
            repeat (5) smp(-300);
        end
        repeat (3) smp(700);
        repeat (5) smp(-300);
        chk("t5_busy_continuous", int'(busy), 1);
        gap = 1'b0;

        // 6: en drop in MEAS holds results; rst in MEAS clears everything
        start_test(0, 1'b0);
        repeat (4) smp(-500);
        repeat (2) begin
            repeat (4) smp(500);
            repeat (4) smp(-500);
        end
        en = 1'b0;
        drive(0, 1'b0);
        chk("t6_busy_en_low", int'(busy), 0);
        chk("t6_hold_period_sum", int'(period_sum), 32);
        chk("t6_hold_peak_min", int'($signed(peak_min)), -300);
        chk("t6_hold_offset", int'($signed(offset)), 200);
        en = 1'b1;
        drive(0, 1'b0);
        repeat (4) smp(-500);
        repeat (4) smp(500);
        repeat (4) smp(-500);
        smp(500);
        chk("t6_busy_meas", int'(busy), 1);
        rst = 1'b1;
        drive(500, 1'b1);
        chk("t6_rst_busy", int'(busy), 0);
        chk("t6_rst_period_sum", int'(period_sum), 0);
        chk("t6_rst_peak_max", int'(peak_max), 0);
        chk("t6_rst_ampl", int'(ampl), 0);
        chk("t6_rst_offset", int'(offset), 0);
        rst = 1'b0;
        en  = 1'b0;
        repeat (3) drive(0, 1'b0);

        chk("scoreboard_empty", q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
